// File: rtl/timing_pkg.sv
// Shared constants, FSM state encoding and one-hot phase decode
// for the timing sequencer.
package timing_pkg;
  localparam int NPH = 16;
  localparam int PW  = 4;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  function automatic logic [NPH-1:0] onehot(input logic [PW-1:0] p);
    logic [NPH-1:0] v;
    v    = '0;
    v[p] = 1'b1;
    return v;
  endfunction
endpackage

// File: rtl/timing_sequencer_if.sv
// Command/status bundle between the issuing controller (master)
// and the timing sequencer (slave).
interface timing_sequencer_if;
  import timing_pkg::*;

  logic           start;
  logic           stop;
  logic           hold;
  logic [PW-1:0]  len;
  logic           cont;
  logic [NPH-1:0] tsig;
  logic [PW-1:0]  phase;
  logic           busy;
  logic           done;
  logic           wrap;

  modport master (output start, stop, hold, len, cont,
                  input  tsig, phase, busy, done, wrap);
  modport slave  (input  start, stop, hold, len, cont,
                  output tsig, phase, busy, done, wrap);
endinterface

// File: rtl/phase_counter.sv
// Phase index counter with synchronous clear, enable and a
// terminal compare against the latched last-phase index.
module phase_counter
  import timing_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          en,
  input  logic [PW-1:0] last,
  output logic [PW-1:0] cnt,
  output logic          at_last
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)    cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en)  cnt <= cnt + 1'b1;
  end

  assign at_last = (cnt == last);

endmodule

// File: rtl/timing_sequencer.sv
// Start/stop/hold front-end driving the 16-phase one-hot timing bus.
//   state | meaning
//   IDLE  | outputs zero, waiting for start
//   RUN   | sweeping phases 0..len_q, tsig = onehot(phase)
//   DONE  | one-cycle done pulse, then back to IDLE
module timing_sequencer
  import timing_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  timing_sequencer_if.slave bus
);

  state_t        state_q, state_d;
  logic [PW-1:0] len_q;
  logic          cont_q;
  logic          stop_pend;
  logic [PW-1:0] cnt;
  logic          at_last;
  logic          run, adv, stop_eff, cnt_clr;

  assign run      = (state_q == RUN);
  assign adv      = run & ~bus.hold;
  assign stop_eff = stop_pend | bus.stop;
  assign cnt_clr  = (state_d != RUN) | (adv & at_last);

  phase_counter u_phase_counter (
    .clk     (clk),
    .reset   (reset),
    .clr     (cnt_clr),
    .en      (adv),
    .last    (len_q),
    .cnt     (cnt),
    .at_last (at_last)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      len_q  <= '0;
      cont_q <= 1'b0;
    end else if (state_q == IDLE && bus.start) begin
      len_q  <= bus.len;
      cont_q <= bus.cont;
    end
  end

  // Held cycles freeze the pending stop along with the phase.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                 stop_pend <= 1'b0;
    else if (state_d != RUN)   stop_pend <= 1'b0;
    else if (adv && bus.stop)  stop_pend <= 1'b1;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = RUN;
      RUN:     if (adv && at_last && (!cont_q || stop_eff)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // wrap marks the terminal phase itself, so it must see this cycle's hold/stop.
  always_comb begin
    bus.tsig  = '0;
    bus.phase = '0;
    bus.busy  = 1'b0;
    bus.done  = 1'b0;
    bus.wrap  = 1'b0;
    case (state_q)
      RUN: begin
        bus.busy  = 1'b1;
        bus.tsig  = onehot(cnt);
        bus.phase = cnt;
        bus.wrap  = adv & at_last & cont_q & ~stop_eff;
      end
      DONE:    bus.done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_timing_sequencer.sv
// Scoreboard bench: each cycle's expected outputs are queued with the
// stimulus and compared mid-cycle against the sequencer outputs.
module tb_timing_sequencer;
  import timing_pkg::*;

  typedef struct {
    logic [NPH-1:0] tsig;
    logic [PW-1:0]  phase;
    logic           busy;
    logic           done;
    logic           wrap;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb[$];

  timing_sequencer_if bus();

  timing_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // p < 0 means not running: tsig and phase zero
  task automatic expect_out(input int p, input logic b, input logic d, input logic w);
    exp_t e;
    e.tsig  = (p < 0) ? '0 : (NPH'(1) << p);
    e.phase = (p < 0) ? '0 : PW'(p);
    e.busy  = b;
    e.done  = d;
    e.wrap  = w;
    sb.push_back(e);
  endtask

  task automatic compare_front();
    exp_t e;
    if (sb.size() == 0) begin
      check("sb_empty", 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    check("tsig",  32'(bus.tsig),  32'(e.tsig));
    check("phase", 32'(bus.phase), 32'(e.phase));
    check("busy",  32'(bus.busy),  32'(e.busy));
    check("done",  32'(bus.done),  32'(e.done));
    check("wrap",  32'(bus.wrap),  32'(e.wrap));
  endtask

  task automatic tick();
    @(negedge clk);
    compare_front();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic st, input logic sp, input logic hd,
                        input logic [PW-1:0] ln, input logic ct);
    bus.start = st;
    bus.stop  = sp;
    bus.hold  = hd;
    bus.len   = ln;
    bus.cont  = ct;
  endtask

  initial begin
    reset = 1'b1;
    set_in(1'b0, 1'b0, 1'b0, '0, 1'b0);
    #12;
    expect_out(-1, 0, 0, 0);
    compare_front();
    reset = 1'b0;
    @(posedge clk);
    #1;

    // single-shot, len 3
    set_in(1'b1, 1'b0, 1'b0, 4'd3, 1'b0);
    expect_out(-1, 0, 0, 0); tick();
    set_in(1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
    for (int p = 0; p <= 3; p++) begin
      expect_out(p, 1, 0, 0); tick();
    end
    expect_out(-1, 0, 1, 0); tick();

    // continuous, len 15: earliest restart in the IDLE cycle after DONE
    set_in(1'b1, 1'b0, 1'b0, 4'd15, 1'b1);
    expect_out(-1, 0, 0, 0); tick();
    set_in(1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
    for (int i = 1; i <= 40; i++) begin
      expect_out((i - 1) % 16, 1, 0, ((i - 1) % 16) == 15); tick();
    end
    bus.stop = 1'b1;
    expect_out(8, 1, 0, 0); tick();
    bus.stop = 1'b0;
    for (int p = 9; p <= 15; p++) begin
      expect_out(p, 1, 0, 0); tick();
    end
    expect_out(-1, 0, 1, 0); tick();

    // continuous len 5, stop at phase 2
    set_in(1'b1, 1'b0, 1'b0, 4'd5, 1'b1);
    expect_out(-1, 0, 0, 0); tick();
    set_in(1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
    for (int p = 0; p <= 5; p++) begin
      bus.stop = (p == 2);
      expect_out(p, 1, 0, 0); tick();
    end
    bus.stop = 1'b0;
    expect_out(-1, 0, 1, 0); tick();
    expect_out(-1, 0, 0, 0); tick();

    // continuous len 5, stop on the terminal phase
    set_in(1'b1, 1'b0, 1'b0, 4'd5, 1'b1);
    expect_out(-1, 0, 0, 0); tick();
    set_in(1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
    for (int p = 0; p <= 5; p++) begin
      bus.stop = (p == 5);
      expect_out(p, 1, 0, 0); tick();
    end
    bus.stop = 1'b0;
    expect_out(-1, 0, 1, 0); tick();
    expect_out(-1, 0, 0, 0); tick();

    // single-shot len 3 with hold at phase 1; hold in IDLE, start/len in RUN ignored
    set_in(1'b1, 1'b0, 1'b1, 4'd3, 1'b0);
    expect_out(-1, 0, 0, 0); tick();
    set_in(1'b0, 1'b1, 1'b0, 4'd0, 1'b1);
    expect_out(0, 1, 0, 0); tick();
    set_in(1'b0, 1'b0, 1'b1, 4'd0, 1'b0);
    expect_out(1, 1, 0, 0); tick();
    expect_out(1, 1, 0, 0); tick();
    bus.hold = 1'b0;
    expect_out(1, 1, 0, 0); tick();
    set_in(1'b1, 1'b0, 1'b0, 4'd15, 1'b1);
    expect_out(2, 1, 0, 0); tick();
    set_in(1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
    expect_out(3, 1, 0, 0); tick();
    expect_out(-1, 0, 1, 0); tick();
    expect_out(-1, 0, 0, 0); tick();

    // len 0 continuous: wrap every unheld cycle, stop ends next cycle
    set_in(1'b1, 1'b0, 1'b0, 4'd0, 1'b1);
    expect_out(-1, 0, 0, 0); tick();
    set_in(1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      expect_out(0, 1, 0, 1); tick();
    end
    bus.hold = 1'b1;
    expect_out(0, 1, 0, 0); tick();
    set_in(1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
    expect_out(0, 1, 0, 0); tick();
    bus.stop = 1'b0;
    expect_out(-1, 0, 1, 0); tick();
    expect_out(-1, 0, 0, 0); tick();

    // async reset mid-sweep at phase 7
    set_in(1'b1, 1'b0, 1'b0, 4'd15, 1'b0);
    expect_out(-1, 0, 0, 0); tick();
    set_in(1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
    for (int p = 0; p <= 6; p++) begin
      expect_out(p, 1, 0, 0); tick();
    end
    expect_out(7, 1, 0, 0);
    @(negedge clk);
    compare_front();
    #1 reset = 1'b1;
    #1;
    expect_out(-1, 0, 0, 0);
    compare_front();
    @(posedge clk);
    #1 reset = 1'b0;

    // restart after reset
    set_in(1'b1, 1'b0, 1'b0, 4'd1, 1'b0);
    expect_out(-1, 0, 0, 0); tick();
    set_in(1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
    expect_out(0, 1, 0, 0); tick();
    expect_out(1, 1, 0, 0); tick();
    expect_out(-1, 0, 1, 0); tick();
    expect_out(-1, 0, 0, 0); tick();

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
